// File: rtl/esm_pkg.sv
// Shared constants and helpers for the ESM pipeline stages.
package esm_pkg;

  localparam int ESM_BS = 16;
  localparam int ESM_DW = 32;

  // Slot index width; a one-slot buffer still gets a 1-bit index.
  function automatic int esm_iw(input int bs);
    return (bs < 2) ? 1 : $clog2(bs);
  endfunction

endpackage

// File: rtl/esm_lowest_free_enc.sv
// Combinational priority encoder: index of the lowest set bit of a free mask.
module esm_lowest_free_enc
  import esm_pkg::*;
#(
  parameter int BS = ESM_BS,
  localparam int IW = esm_iw(BS)
) (
  input  logic [BS-1:0] free_mask,
  output logic [IW-1:0] index,
  output logic          any_free
);

  always_comb begin
    index = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = BS - 1; i >= 0; i--) begin
      if (free_mask[i]) index = IW'(i);
    end
  end

  assign any_free = |free_mask;

endmodule

// File: rtl/esm_candidate_buffer.sv
// Slot buffer publishing an occupancy mask as the mapping stage's candidate list;
// a selected slot is emitted on a valid/ready output and then freed.
module esm_candidate_buffer
  import esm_pkg::*;
#(
  parameter int BS = ESM_BS,
  parameter int DW = ESM_DW,
  localparam int IW = esm_iw(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          sel_valid,
  input  logic [IW-1:0] sel_index,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [BS-1:0] cand_list,
  output logic [IW:0]   occupancy,
  output logic          full,
  output logic          empty,
  output logic          sel_err
);

  logic [DW-1:0] mem [BS];

  logic [IW-1:0] wr_index;
  logic          any_free;
  logic          wr_fire;
  logic          rd_accept;
  logic          sel_in_range;
  logic          sel_occupied;
  logic          rd_fire;
  logic          err_next;
  logic [BS-1:0] cand_next;
  logic [IW:0]   occ_next;
  logic          out_valid_next;

  esm_lowest_free_enc #(.BS(BS)) u_free_enc (
    .free_mask (~cand_list),
    .index     (wr_index),
    .any_free  (any_free)
  );

  assign in_ready = !full;

  always_comb begin
    wr_fire        = in_valid && !full && any_free;
    rd_accept      = sel_valid && (!out_valid || out_ready);
    sel_in_range   = ({1'b0, sel_index} < (IW+1)'(BS));
    sel_occupied   = sel_in_range && cand_list[sel_index];
    rd_fire        = rd_accept && sel_occupied;
    err_next       = rd_accept && !sel_occupied;

    // Write slot comes from the pre-read mask, so it never collides with the read slot.
    cand_next = cand_list;
    if (wr_fire) cand_next[wr_index] = 1'b1;
    if (rd_fire) cand_next[sel_index] = 1'b0;

    occ_next = occupancy + (IW+1)'(wr_fire) - (IW+1)'(rd_fire);

    out_valid_next = out_valid;
    if (rd_fire) out_valid_next = 1'b1;
    else if (out_ready) out_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_index] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_list <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else begin
      cand_list <= cand_next;
      occupancy <= occ_next;
      full      <= (occ_next == (IW+1)'(BS));
      empty     <= (occ_next == '0);
      out_valid <= out_valid_next;
      if (rd_fire) out_data <= mem[sel_index];
      sel_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_esm_candidate_buffer.sv
// Directed bench for esm_candidate_buffer with hand-computed expectations.
module tb_esm_candidate_buffer;
  import esm_pkg::*;

  localparam int BS = 16;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          sel_valid = 1'b0;
  logic [IW-1:0] sel_index = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [BS-1:0] cand_list;
  logic [IW:0]   occupancy;
  logic          full;
  logic          empty;
  logic          sel_err;

  int vectors = 0;
  int miscompares = 0;

  esm_candidate_buffer #(.BS(BS), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel_valid (sel_valid),
    .sel_index (sel_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cand_list (cand_list),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      $display("vec %0d %s: %0h", vectors, tag, obs);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("popcount", 64'($countones(cand_list)), 64'(occupancy));
  endtask

  initial begin
    int s;
    #12;
    chk("rst_cand", 64'(cand_list), 64'h0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_odata", 64'(out_data), 64'h0);
    chk("rst_err", 64'(sel_err), 64'd0);
    chk("rst_inrdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four writes A0..A3 land in slots 0..3.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("fill4_cand", 64'(cand_list), 64'h000F);
    chk("fill4_occ", 64'(occupancy), 64'd4);
    chk("fill4_empty", 64'(empty), 64'd0);

    // Read slot 2.
    out_ready = 1'b1;
    sel_valid = 1'b1;
    sel_index = 4'd2;
    tick();
    sel_valid = 1'b0;
    chk("rd2_data", 64'(out_data), 64'hA2);
    chk("rd2_valid", 64'(out_valid), 64'd1);
    chk("rd2_cand", 64'(cand_list), 64'h000B);
    chk("rd2_occ", 64'(occupancy), 64'd3);

    // New write refills slot 2 while the output drains.
    in_valid = 1'b1;
    in_data  = 32'hB2;
    tick();
    in_valid = 1'b0;
    chk("refill_cand", 64'(cand_list), 64'h000F);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Back-to-back reads of slots 2, 0, 3.
    sel_valid = 1'b1;
    sel_index = 4'd2;
    tick();
    chk("rd2b_data", 64'(out_data), 64'hB2);
    sel_index = 4'd0;
    tick();
    chk("rd0_data", 64'(out_data), 64'hA0);
    chk("rd0_valid", 64'(out_valid), 64'd1);
    sel_index = 4'd3;
    tick();
    chk("rd3_data", 64'(out_data), 64'hA3);
    sel_valid = 1'b0;
    tick();
    chk("b2b_cand", 64'(cand_list), 64'h0002);
    chk("b2b_valid", 64'(out_valid), 64'd0);

    // Fill remaining 15 slots: 0, 2, 3, ..., 15.
    for (int k = 0; k < 15; k++) begin
      s = (k == 0) ? 0 : k + 1;
      in_valid = 1'b1;
      in_data  = 32'hC00 + 32'(s);
      tick();
    end
    chk("full_flag", 64'(full), 64'd1);
    chk("full_inrdy", 64'(in_ready), 64'd0);
    chk("full_cand", 64'(cand_list), 64'hFFFF);

    // Write blocked while full even though slot 5 is read this cycle.
    in_data   = 32'hD5;
    sel_valid = 1'b1;
    sel_index = 4'd5;
    tick();
    sel_valid = 1'b0;
    chk("blk_occ", 64'(occupancy), 64'd15);
    chk("blk_full", 64'(full), 64'd0);
    chk("blk_inrdy", 64'(in_ready), 64'd1);
    chk("blk_data", 64'(out_data), 64'hC05);
    chk("blk_cand", 64'(cand_list), 64'hFFDF);
    tick();
    in_valid = 1'b0;
    chk("slot5_cand", 64'(cand_list), 64'hFFFF);
    chk("slot5_full", 64'(full), 64'd1);
    sel_valid = 1'b1;
    sel_index = 4'd5;
    tick();
    chk("slot5_data", 64'(out_data), 64'hD5);

    // Empty slot 7, let the output drain, then select it again.
    sel_index = 4'd7;
    tick();
    chk("rd7_data", 64'(out_data), 64'hC07);
    sel_valid = 1'b0;
    tick();
    chk("pre_err_valid", 64'(out_valid), 64'd0);
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("err_pulse", 64'(sel_err), 64'd1);
    chk("err_valid", 64'(out_valid), 64'd0);
    chk("err_cand", 64'(cand_list), 64'hFF5F);
    chk("err_occ", 64'(occupancy), 64'd14);
    tick();
    chk("err_clear", 64'(sel_err), 64'd0);

    // Stall: output holds C00 while a selection of slot 1 waits.
    out_ready = 1'b0;
    sel_valid = 1'b1;
    sel_index = 4'd0;
    tick();
    chk("stall_data0", 64'(out_data), 64'hC00);
    sel_index = 4'd1;
    tick();
    chk("stall_data", 64'(out_data), 64'hC00);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_cand", 64'(cand_list), 64'hFF5E);
    chk("stall_err", 64'(sel_err), 64'd0);
    tick();
    chk("stall_data2", 64'(out_data), 64'hC00);
    out_ready = 1'b1;
    tick();
    chk("unstall_data", 64'(out_data), 64'hA1);
    chk("unstall_cand", 64'(cand_list), 64'hFF5C);

    // Reads of 2, 3, 4 bring occupancy to 9.
    for (int i = 2; i < 5; i++) begin
      sel_index = IW'(i);
      tick();
      chk("pre_rst_data", 64'(out_data), 64'hC00 + 64'(i));
    end
    sel_valid = 1'b0;
    chk("pre_rst_occ", 64'(occupancy), 64'd9);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cand", 64'(cand_list), 64'h0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_inrdy", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
